// File: rtl/sc_shift_sequencer.sv
// Load/shift/done sequencer that drives a downstream shift register for a programmable number of cycles.
// Optional macro SC_SHIFT_SEQUENCER_ABORT_EN adds an active-low abort input honoured in LOAD and SHIFT.
module sc_shift_sequencer #(
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int DATAWIDTH_COUNT                = 4
) (
    input  logic                                      SC_ShiftSequencer_CLOCK_50,
    input  logic                                      SC_ShiftSequencer_Reset_InLow,
    input  logic                                      SC_ShiftSequencer_Start_InLow,
    input  logic                                      SC_ShiftSequencer_Direction_In,
    input  logic [DATAWIDTH_COUNT-1:0]                SC_ShiftSequencer_Count_In,
`ifdef SC_SHIFT_SEQUENCER_ABORT_EN
    input  logic                                      SC_ShiftSequencer_Abort_InLow,
`endif
    output logic                                      SC_ShiftSequencer_Load_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_ShiftSequencer_ShiftSelection_OutLow,
    output logic                                      SC_ShiftSequencer_Busy_Out,
    output logic                                      SC_ShiftSequencer_Done_Out,
    output logic [1:0]                                o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_HOLD  = '0;
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_LEFT  = DATAWIDTH_REGSHIFTER_SELECTION'(1);
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_RIGHT = DATAWIDTH_REGSHIFTER_SELECTION'(2);

    state_t                     r_state;
    logic [DATAWIDTH_COUNT-1:0] r_count;
    logic                       r_dir;
    logic                       w_abort;

`ifdef SC_SHIFT_SEQUENCER_ABORT_EN
    assign w_abort = ~SC_ShiftSequencer_Abort_InLow;
`else
    assign w_abort = 1'b0;
`endif

    // Inputs are only looked at in IDLE; direction and count are frozen for the whole sequence.
    always_ff @(posedge SC_ShiftSequencer_CLOCK_50 or negedge SC_ShiftSequencer_Reset_InLow) begin
        if (!SC_ShiftSequencer_Reset_InLow) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_dir   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!SC_ShiftSequencer_Start_InLow) begin
                        r_state <= ST_LOAD;
                        r_dir   <= SC_ShiftSequencer_Direction_In;
                        r_count <= SC_ShiftSequencer_Count_In;
                    end
                end
                ST_LOAD: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else if (r_count == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else if (r_count <= DATAWIDTH_COUNT'(1)) begin
                        // Last shift cycle: land on zero and leave, so the counter cannot wrap.
                        r_state <= ST_DONE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count - DATAWIDTH_COUNT'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    always_comb begin
        SC_ShiftSequencer_Load_OutLow           = 1'b1;
        SC_ShiftSequencer_ShiftSelection_OutLow = SEL_HOLD;
        SC_ShiftSequencer_Busy_Out              = 1'b0;
        SC_ShiftSequencer_Done_Out              = 1'b0;
        case (r_state)
            ST_LOAD: begin
                SC_ShiftSequencer_Load_OutLow = 1'b0;
                SC_ShiftSequencer_Busy_Out    = 1'b1;
            end
            ST_SHIFT: begin
                SC_ShiftSequencer_ShiftSelection_OutLow = r_dir ? SEL_RIGHT : SEL_LEFT;
                SC_ShiftSequencer_Busy_Out              = 1'b1;
            end
            ST_DONE: begin
                SC_ShiftSequencer_Busy_Out = 1'b1;
                SC_ShiftSequencer_Done_Out = 1'b1;
            end
            default: begin
                SC_ShiftSequencer_Load_OutLow = 1'b1;
            end
        endcase
    end

    assign o_dbg_state = r_state;

endmodule
